// File: rtl/gray_counter_n.sv
// N-bit Gray-code up/down counter with synchronous load.
// State is held in Gray code; a registered stage provides the binary view.
module gray_counter_n #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_out,
    output logic             wrap
);

    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] bin_q;
    logic             wrap_q;
    logic [WIDTH-1:0] bin_cur;
    logic [WIDTH-1:0] bin_step;
    logic             step_wrap;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Single-cycle decode -> +/-1 -> encode chain feeding the state register.
    always_comb begin
        bin_cur   = gray2bin(gray_q);
        bin_step  = up ? bin_cur + 1'b1 : bin_cur - 1'b1;
        step_wrap = up ? (&bin_step) : ~(|bin_step);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else if (load) begin
            gray_q <= bin2gray(din);
            wrap_q <= 1'b0;
        end else if (en) begin
            gray_q <= bin2gray(bin_step);
            wrap_q <= step_wrap;
        end else begin
            wrap_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q <= '0;
        end else begin
            bin_q <= gray2bin(gray_q);
        end
    end

    assign gray_out = gray_q;
    assign bin_out  = bin_q;
    assign wrap     = wrap_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// Directed scoreboard bench for gray_counter_n at WIDTH=4 and WIDTH=8.
module tb_gray_counter_n;

    typedef struct {
        logic [7:0] g;
        logic [7:0] b;
        logic       w;
        logic       stepped;
        logic [7:0] prev_g;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en4 = 1'b0, up4 = 1'b0, load4 = 1'b0;
    logic [3:0] din4 = '0;
    logic [3:0] gray4, bin4;
    logic       wrap4;
    logic       en8 = 1'b0, up8 = 1'b0, load8 = 1'b0;
    logic [7:0] din8 = '0;
    logic [7:0] gray8, bin8;
    logic       wrap8;

    int   passed = 0;
    int   total  = 0;
    int   m_b[2];
    exp_t sb[$];

    gray_counter_n #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .up(up4), .load(load4),
        .din(din4), .gray_out(gray4), .bin_out(bin4), .wrap(wrap4)
    );

    gray_counter_n #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en8), .up(up8), .load(load8),
        .din(din8), .gray_out(gray8), .bin_out(bin8), .wrap(wrap8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] enc(input int b);
        logic [7:0] v;
        v = b[7:0];
        return v ^ (v >> 1);
    endfunction

    // Drive one cycle on the selected instance, scoreboard its outputs.
    task automatic step(input bit wide, input bit ld, input logic [7:0] d,
                        input bit e, input bit u);
        exp_t x, y;
        int   mask, old, nxt;
        @(negedge clk);
        en4 = 0; up4 = 0; load4 = 0; din4 = '0;
        en8 = 0; up8 = 0; load8 = 0; din8 = '0;
        if (wide) begin
            en8 = e; up8 = u; load8 = ld; din8 = d;
        end else begin
            en4 = e; up4 = u; load4 = ld; din4 = d[3:0];
        end
        mask = wide ? 255 : 15;
        old  = m_b[wide];
        if (ld) nxt = int'(d) & mask;
        else if (e) nxt = (u ? old + 1 : old - 1) & mask;
        else nxt = old;
        m_b[wide] = nxt;
        x.g       = enc(nxt);
        x.b       = old[7:0];
        x.w       = !ld && e && (u ? nxt == mask : nxt == 0);
        x.stepped = e && !ld;
        x.prev_g  = enc(old);
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            $error("FAIL scoreboard_empty: got 0 expected 1");
        end else begin
            y = sb.pop_front();
            if (wide) begin
                check("gray8", gray8, y.g);
                check("bin8", bin8, y.b);
                check("wrap8", {7'b0, wrap8}, {7'b0, y.w});
                if (y.stepped)
                    check("onebit8", 8'($countones(gray8 ^ y.prev_g)), 8'd1);
            end else begin
                check("gray4", {4'b0, gray4}, y.g);
                check("bin4", {4'b0, bin4}, y.b);
                check("wrap4", {7'b0, wrap4}, {7'b0, y.w});
                if (y.stepped)
                    check("onebit4", 8'($countones(gray4 ^ y.prev_g[3:0])), 8'd1);
            end
        end
    endtask

    logic [3:0] up_tbl [17];

    initial begin
        up_tbl = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                   4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                   4'b1011, 4'b1001, 4'b1000, 4'b0000, 4'b0001};
        m_b[0] = 0;
        m_b[1] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Count a little, then reset asynchronously mid-cycle while enabled
        repeat (3) step(0, 0, 8'd0, 1, 1);
        @(negedge clk);
        en4 = 1'b1; up4 = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_gray", {4'b0, gray4}, 8'd0);
        check("rst_bin", {4'b0, bin4}, 8'd0);
        check("rst_wrap", {7'b0, wrap4}, 8'd0);
        @(posedge clk);
        #1;
        check("rst_hold_gray", {4'b0, gray4}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        en4 = 1'b0;
        m_b[0] = 0;
        m_b[1] = 0;
        sb.delete();
        repeat (5) step(0, 0, 8'd0, 0, 1);

        // Full up cycle against the literal Gray sequence
        for (int i = 0; i < 17; i++) begin
            step(0, 0, 8'd0, 1, 1);
            check("up_tbl", {4'b0, gray4}, {4'b0, up_tbl[i]});
        end

        // Down wrap
        step(0, 1, 8'd1, 0, 0);
        step(0, 0, 8'd0, 1, 0);
        check("dn_wrap_gray", {4'b0, gray4}, 8'h00);
        check("dn_wrap_w", {7'b0, wrap4}, 8'd1);
        step(0, 0, 8'd0, 1, 0);
        check("dn_15_gray", {4'b0, gray4}, 8'h08);
        step(0, 0, 8'd0, 0, 0);
        check("dn_15_bin", {4'b0, bin4}, 8'd15);

        // Load overrides enable
        step(0, 1, 8'd10, 1, 1);
        check("ld_gray", {4'b0, gray4}, 8'h0F);
        step(0, 0, 8'd0, 0, 0);
        check("ld_bin", {4'b0, bin4}, 8'h0A);

        // Direction flip around gray 0110
        step(0, 1, 8'd3, 0, 0);
        step(0, 0, 8'd0, 1, 1);
        check("flip_start", {4'b0, gray4}, 8'h06);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 8'd0, 1, (i % 2 == 0));
            check("flip_gray", {4'b0, gray4}, (i % 2 == 0) ? 8'h07 : 8'h06);
        end

        // Wide instance wrap
        step(1, 1, 8'hFE, 0, 0);
        check("w8_ld", gray8, 8'b1000_0001);
        step(1, 0, 8'd0, 1, 1);
        check("w8_ff", gray8, 8'b1000_0000);
        step(1, 0, 8'd0, 1, 1);
        check("w8_00", gray8, 8'b0000_0000);
        step(1, 0, 8'd0, 1, 1);
        check("w8_01", gray8, 8'b0000_0001);
        step(1, 0, 8'd0, 0, 0);
        check("w8_bin", bin8, 8'h01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
